// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: default
// parameter values and the fetch state encoding.
package fetch_unit_pkg;

  localparam int          DEF_WORD_SIZE  = 16;
  localparam int unsigned DEF_RESET_PC   = 32'h0000_0000;
  localparam int          DEF_FIFO_DEPTH = 2;

  // ST_DROP is the drop flag: an access is still outstanding at the cache,
  // but its word belongs to a path that a redirect has abandoned.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_buffer.sv
// Instruction buffer between the icache interface and decode.
// Synchronous FIFO of {pc, inst} entries with flush. The head is held in a
// register so it keeps its last value when the buffer runs empty or is
// flushed.
module fetch_unit_buffer
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH = 2 * DEF_WORD_SIZE,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic             pop_eff;

  // A pop on an empty buffer is ignored.
  assign pop_eff    = pop && (count != '0);
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);
  assign head_valid = (count != '0);

  // Pointer and occupancy bookkeeping; flush empties the buffer in one edge.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_eff) rd_ptr <= rd_ptr_inc;
      count <= count + CNT_W'(push) - CNT_W'(pop_eff);
    end
  end

  // Storage array write port.
  // NOTE: the array has no reset; nothing reads a slot before it is
  // written, and leaving it out keeps the storage a plain register file.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Head register: load the entry that will be at the head after this edge;
  // hold otherwise, including across a flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_data <= '0;
    end else if (!flush) begin
      if (pop_eff && (count > CNT_W'(1)))
        head_data <= mem[rd_ptr_inc];
      else if (push && ((count == '0) || pop_eff))
        head_data <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end. Owns the PC, issues one word read at a time
// to the icache, and fills the instruction buffer that feeds decode.
// The cache address never changes while an access is outstanding; a
// redirect during a miss parks the old address until the cache answers.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   WORD_SIZE  = DEF_WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = WORD_SIZE'(DEF_RESET_PC),
  parameter int                   FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 ic_read,
  output logic [WORD_SIZE-1:0] ic_addr,
  input  logic [WORD_SIZE-1:0] ic_data,
  input  logic                 ic_done,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 halt,
  output logic                 if_valid,
  output logic [WORD_SIZE-1:0] if_inst,
  output logic [WORD_SIZE-1:0] if_pc,
  input  logic                 id_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e           state;
  fetch_state_e           state_next;
  logic [WORD_SIZE-1:0]   pc;
  logic [WORD_SIZE-1:0]   held_addr;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_next;
  logic [2*WORD_SIZE-1:0] head;
  logic                   push;
  logic                   pop;
  logic                   issue_ok;

  // Decode takes the head on this edge; a word is kept only if it is for the
  // current path and no redirect arrives alongside it.
  assign pop  = if_valid && id_ready;
  assign push = (state == ST_FETCH) && ic_done && !redirect;

  // Buffer occupancy after this edge; a new access reserves a free slot.
  always_comb begin
    count_next = count + CNT_W'(push) - CNT_W'(pop);
    if (redirect) count_next = '0;
  end

  assign issue_ok = !halt && (count_next < CNT_W'(FIFO_DEPTH));

  // State register; reset abandons any outstanding access immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic: an access ends only on ic_done; a redirect without
  // ic_done turns the outstanding access into one to be discarded.
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (issue_ok) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (ic_done)       state_next = issue_ok ? ST_FETCH : ST_IDLE;
        else if (redirect) state_next = ST_DROP;
      end
      ST_DROP: begin
        if (ic_done) state_next = issue_ok ? ST_FETCH : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Cache interface outputs: the parked address is shown while dropping.
  always_comb begin
    ic_read = 1'b0;
    ic_addr = pc;
    case (state)
      ST_FETCH: ic_read = 1'b1;
      ST_DROP: begin
        ic_read = 1'b1;
        ic_addr = held_addr;
      end
      default: ic_read = 1'b0;
    endcase
  end

  // PC: a redirect wins; otherwise advance (mod 2^WORD_SIZE) on each kept word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      pc <= RESET_PC;
    else if (redirect) pc <= redirect_pc;
    else if (push)     pc <= pc + WORD_SIZE'(1);
  end

  // Park the in-flight address when a redirect lands mid-access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      held_addr <= RESET_PC;
    else if ((state == ST_FETCH) && redirect && !ic_done)
      held_addr <= pc;
  end

  fetch_unit_buffer #(
    .WIDTH (2 * WORD_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_buffer (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .pop        (pop),
    .flush      (redirect),
    .push_data  ({pc, ic_data}),
    .count      (count),
    .head_valid (if_valid),
    .head_data  (head)
  );

  assign if_pc   = head[2*WORD_SIZE-1:WORD_SIZE];
  assign if_inst = head[WORD_SIZE-1:0];

endmodule
